multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Main control FSM for the multicycle RV32I core, replacing the fixed-latency controller. It decodes `op`, sequences the datapath enables and multiplexer selects, and stalls on a ready-based memory handshake. It adds JALR, LUI and AUIPC, and makes JAL write back its link register. It sits between the instruction register and the datapath, alongside the ALU decoder, which consumes `ALUOp`.

## Interface
- `WAIT_MAX`, default 15: maximum wait cycles per memory access before a timeout; range 1..255.
- `WAIT_W`, default `$clog2(WAIT_MAX+1)`: width of the wait counter.
- `clk`  in  1  core clock; all state changes on the rising edge.
- `reset_n`  in  1  asynchronous active-low reset.
- `op`  in  7  opcode field from the instruction register.
- `mem_ready`  in  1  memory has completed the current request this cycle.
- `mem_req`  out  1  memory access request.
- `PCUpdate`, `Branch`, `RegWrite`, `MemWrite`, `IRWrite`, `AdrSrc`  out  1 each  datapath enables and selects.
- `ALUSrcA`  out  2  ALU operand A select: 00 = PC, 01 = OldPC, 10 = rs1, 11 = zero.
- `ALUSrcB`  out  2  ALU operand B select: 00 = rs2, 01 = imm, 10 = constant 4.
- `ResultSrc`  out  2  result select: 00 = ALUOut, 01 = Data, 10 = ALUResult.
- `ALUOp`  out  2  to the ALU decoder: 00 = add, 01 = branch compare, 10 = funct-decoded.
- `trap`  out  1  sticky fault flag.
- `trap_cause`  out  2  fault cause: 01 = illegal opcode, 10 = memory timeout.
- `state`  out  4  current state, for debug.

## Operation
- Moore outputs are decoded from the state. Every output not listed for a state is 0.
- Exception: `IRWrite`, `PCUpdate` (in FETCH) and `MemWrite` are qualified with `mem_ready`.
- States and transitions:
  - FETCH: `mem_req`=1, A=00, B=10, ResultSrc=10. When `mem_ready`=1: `IRWrite`=1, `PCUpdate`=1, go to DECODE. Otherwise hold.
  - DECODE: A=01, B=01 (computes branch/JAL target into ALUOut). Next state by `op`:
    - 0000011 / 0100011 → MEMADR
    - 0110011 → EXECR
    - 0010011 → EXECI
    - 1101111 → JAL
    - 1100111 → JALR
    - 0110111 → LUI
    - 0010111 → AUIPC
    - 1100011 → BRANCH
    - any other opcode → illegal (see Configuration).
  - MEMADR: A=10, B=01. Go to MEMREAD for a load, MEMWRITE for a store.
  - MEMREAD: `mem_req`=1, `AdrSrc`=1. On `mem_ready` go to MEMWB.
  - MEMWB: `RegWrite`=1, ResultSrc=01. Go to FETCH.
  - MEMWRITE: `mem_req`=1, `AdrSrc`=1, `MemWrite`=`mem_ready`. On `mem_ready` go to FETCH.
  - EXECR: A=10, B=00, ALUOp=10. EXECI: A=10, B=01, ALUOp=10. Both go to ALUWB.
  - JALR: A=10, B=01 (target into ALUOp path, ALUOut). Go to JAL.
  - JAL: A=01, B=10, ResultSrc=00, `PCUpdate`=1. Go to ALUWB, which writes OldPC+4 as the link.
  - LUI: A=11, B=01. AUIPC: A=01, B=01. Both go to ALUWB.
  - ALUWB: `RegWrite`=1, ResultSrc=00. Go to FETCH.
  - BRANCH: A=10, B=00, ALUOp=01, `Branch`=1. Go to FETCH.
  - TRAP: all enables 0, `trap`=1. Held until reset.
- Wait counter:
  - Clears on entry to FETCH, MEMREAD and MEMWRITE.
  - Increments each cycle `mem_req`=1 and `mem_ready`=0, saturating at `WAIT_MAX`.
  - When the counter equals `WAIT_MAX` and `mem_ready`=0, a timeout is raised.
  - `mem_ready` arriving in that same cycle wins; no timeout is raised.

## Timing
- Reset: while `reset_n`=0, the state is FETCH and every output is forced to 0, including `mem_req`.
- Outputs are released on the first `clk` edge after `reset_n` rises; `mem_req`=1 from that cycle.
- Reset asserted mid-instruction aborts it immediately. No write enable is asserted after the falling edge of `reset_n`.
- Latency with zero wait states, in cycles per instruction:
  - load 5
  - store 4
  - R-type, I-type, LUI, AUIPC 4
  - JAL 4
  - JALR 5
  - branch 3
- Each wait cycle adds 1 cycle.
- `mem_ready` is ignored outside FETCH, MEMREAD and MEMWRITE.

## Configuration
- `MCTRL_TRAP_EN` defined:
  - An illegal opcode goes DECODE → TRAP with cause 01.
  - A timeout goes to TRAP with cause 10.
  - `trap` and `trap_cause` are registered and sticky until reset.
- `MCTRL_TRAP_EN` undefined:
  - An illegal opcode goes DECODE → FETCH, i.e. it executes as a NOP.
  - The wait counter is not built; waits are unbounded.
  - `trap` and `trap_cause` are tied to 0, and the TRAP state is unreachable.

## Structure
- `ctrl_pkg` holds:
  - the state encoding enum (4 bits)
  - the opcode constants
  - the `ALUSrcA`, `ALUSrcB`, `ResultSrc` and `ALUOp` encodings
  - the trap cause codes.
- One sub-module, `mctrl_wait_timer`: the saturating wait counter with clear, enable and timeout outputs. It is instantiated only under `MCTRL_TRAP_EN`.

## Test plan
- Reset, then `op`=0110011 with `mem_ready`=1 → state sequence FETCH, DECODE, EXECR, ALUWB, FETCH. `RegWrite`=1 only in ALUWB; ALUOp=10 in EXECR.
- Load with `mem_ready` low for 3 cycles in MEMREAD → MEMREAD held 4 cycles, MEMWB follows, total 8 cycles. `IRWrite` pulses exactly once.
- Store with `mem_ready` pulsed late → `MemWrite`=1 only in the ready cycle; next state FETCH.
- JALR (`op`=1100111) → JALR with A=10/B=01, then JAL with `PCUpdate`=1, then ALUWB with `RegWrite`=1.
- `op`=0000000 → with `MCTRL_TRAP_EN`: TRAP, `trap`=1, `trap_cause`=01, held until `reset_n` pulses. Without it: back to FETCH, `trap`=0.
- `WAIT_MAX`=15 with `mem_ready` held 0 in FETCH → TRAP on the 16th wait cycle, cause 10. `reset_n` low mid-wait → all outputs 0 asynchronously.

Source files
------------

// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - state, opcode, mux-select and trap-cause encodings for multicycle_ctrl
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_JAL      = 4'd8,
    S_JALR     = 4'd9,
    S_LUI      = 4'd10,
    S_AUIPC    = 4'd11,
    S_ALUWB    = 4'd12,
    S_BRANCH   = 4'd13,
    S_TRAP     = 4'd14
  } state_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] ALUOP_ADD    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT  = 2'b10;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

endpackage

// File: rtl/mctrl_wait_timer.sv
// rtl/mctrl_wait_timer.sv - saturating memory wait counter with timeout flag
module mctrl_wait_timer #(
  parameter int WAIT_MAX = 15,
  parameter int WAIT_W   = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic timeout_o
);

  localparam logic [WAIT_W-1:0] CNT_MAX = WAIT_W'(WAIT_MAX);

  logic [WAIT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (en_i && cnt_q != CNT_MAX)
      cnt_d = cnt_q + WAIT_W'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign timeout_o = en_i && (cnt_q == CNT_MAX);

endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multicycle RV32I control FSM with ready-based memory handshake
// MCTRL_TRAP_EN adds illegal-opcode and memory-timeout traps via mctrl_wait_timer.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int WAIT_MAX = 15,
  parameter int WAIT_W   = $clog2(WAIT_MAX + 1)
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [6:0] op,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       PCUpdate,
  output logic       Branch,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUOp,
  output logic       trap,
  output logic [1:0] trap_cause,
  output logic [3:0] state
);

  if (WAIT_MAX < 1 || WAIT_MAX > 255 || WAIT_W < 1) begin : g_bad_wait_cfg
    $error("multicycle_ctrl: WAIT_MAX must be within 1..255");
  end

  // run_q holds every output low from reset until the first clock edge after release
  logic   run_q;
  state_e state_q, state_d;
  logic   timeout;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:    if (mem_ready) state_d = S_DECODE; else if (timeout) state_d = S_TRAP;
      S_DECODE: begin
        case (op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECR;
          OP_ITYPE:          state_d = S_EXECI;
          OP_JAL:            state_d = S_JAL;
          OP_JALR:           state_d = S_JALR;
          OP_LUI:            state_d = S_LUI;
          OP_AUIPC:          state_d = S_AUIPC;
          OP_BRANCH:         state_d = S_BRANCH;
`ifdef MCTRL_TRAP_EN
          default:           state_d = S_TRAP;
`else
          default:           state_d = S_FETCH;
`endif
        endcase
      end
      S_MEMADR:   state_d = (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (mem_ready) state_d = S_MEMWB; else if (timeout) state_d = S_TRAP;
      S_MEMWRITE: if (mem_ready) state_d = S_FETCH; else if (timeout) state_d = S_TRAP;
      S_MEMWB, S_ALUWB, S_BRANCH: state_d = S_FETCH;
      S_EXECR, S_EXECI, S_LUI, S_AUIPC, S_JAL: state_d = S_ALUWB;
      S_JALR:     state_d = S_JAL;
      S_TRAP:     state_d = S_TRAP;
      default:    state_d = S_FETCH;
    endcase
  end

  always_comb begin
    mem_req   = 1'b0;
    PCUpdate  = 1'b0;
    Branch    = 1'b0;
    RegWrite  = 1'b0;
    MemWrite  = 1'b0;
    IRWrite   = 1'b0;
    AdrSrc    = 1'b0;
    ALUSrcA   = SRCA_PC;
    ALUSrcB   = SRCB_RS2;
    ResultSrc = RES_ALUOUT;
    ALUOp     = ALUOP_ADD;
    if (run_q) begin
      case (state_q)
        S_FETCH: begin
          mem_req   = 1'b1;
          ALUSrcB   = SRCB_FOUR;
          ResultSrc = RES_ALURESULT;
          IRWrite   = mem_ready;
          PCUpdate  = mem_ready;
        end
        S_DECODE:   begin ALUSrcA = SRCA_OLDPC; ALUSrcB = SRCB_IMM; end
        S_MEMADR:   begin ALUSrcA = SRCA_RS1;   ALUSrcB = SRCB_IMM; end
        S_MEMREAD:  begin mem_req = 1'b1; AdrSrc = 1'b1; end
        S_MEMWB:    begin RegWrite = 1'b1; ResultSrc = RES_DATA; end
        S_MEMWRITE: begin mem_req = 1'b1; AdrSrc = 1'b1; MemWrite = mem_ready; end
        S_EXECR:    begin ALUSrcA = SRCA_RS1; ALUSrcB = SRCB_RS2; ALUOp = ALUOP_FUNCT; end
        S_EXECI:    begin ALUSrcA = SRCA_RS1; ALUSrcB = SRCB_IMM; ALUOp = ALUOP_FUNCT; end
        S_JALR:     begin ALUSrcA = SRCA_RS1; ALUSrcB = SRCB_IMM; end
        S_JAL: begin
          ALUSrcA   = SRCA_OLDPC;
          ALUSrcB   = SRCB_FOUR;
          ResultSrc = RES_ALUOUT;
          PCUpdate  = 1'b1;
        end
        S_LUI:      begin ALUSrcA = SRCA_ZERO;  ALUSrcB = SRCB_IMM; end
        S_AUIPC:    begin ALUSrcA = SRCA_OLDPC; ALUSrcB = SRCB_IMM; end
        S_ALUWB:    begin RegWrite = 1'b1; ResultSrc = RES_ALUOUT; end
        S_BRANCH: begin
          ALUSrcA = SRCA_RS1;
          ALUSrcB = SRCB_RS2;
          ALUOp   = ALUOP_BRANCH;
          Branch  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign state = run_q ? state_q : S_FETCH;

`ifdef MCTRL_TRAP_EN
  logic       trap_q;
  logic [1:0] cause_q;

  mctrl_wait_timer #(
    .WAIT_MAX (WAIT_MAX),
    .WAIT_W   (WAIT_W)
  ) u_wait_timer (
    .clk_i     (clk),
    .rst_ni    (reset_n),
    .clr_i     (run_q && (state_d != state_q)),
    .en_i      (mem_req && !mem_ready),
    .timeout_o (timeout)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run_q   <= 1'b0;
      state_q <= S_FETCH;
      trap_q  <= 1'b0;
      cause_q <= CAUSE_NONE;
    end else begin
      run_q <= 1'b1;
      if (run_q) begin
        state_q <= state_d;
        if (state_d == S_TRAP && state_q != S_TRAP) begin
          trap_q  <= 1'b1;
          cause_q <= (state_q == S_DECODE) ? CAUSE_ILLEGAL : CAUSE_TIMEOUT;
        end
      end
    end
  end

  assign trap       = trap_q;
  assign trap_cause = cause_q;
`else
  assign timeout = 1'b0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run_q   <= 1'b0;
      state_q <= S_FETCH;
    end else begin
      run_q <= 1'b1;
      if (run_q)
        state_q <= state_d;
    end
  end

  assign trap       = 1'b0;
  assign trap_cause = CAUSE_NONE;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - self-checking bench: per-cycle trace model built from instruction classes
module tb_multicycle_ctrl;
  import ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [6:0] op;
  logic       mem_ready;
  logic       mem_req, PCUpdate, Branch, RegWrite, MemWrite, IRWrite, AdrSrc, trap;
  logic [1:0] ALUSrcA, ALUSrcB, ResultSrc, ALUOp, trap_cause;
  logic [3:0] state;

  always #5 clk = ~clk;

  multicycle_ctrl #(.WAIT_MAX(15)) dut (
    .clk(clk), .reset_n(reset_n), .op(op), .mem_ready(mem_ready),
    .mem_req(mem_req), .PCUpdate(PCUpdate), .Branch(Branch), .RegWrite(RegWrite),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc), .ALUOp(ALUOp), .trap(trap),
    .trap_cause(trap_cause), .state(state)
  );

  logic [17:0] obs;
  assign obs = {mem_req, PCUpdate, Branch, RegWrite, MemWrite, IRWrite, AdrSrc,
                ALUSrcA, ALUSrcB, ResultSrc, ALUOp, trap, trap_cause};

  typedef struct {
    state_e     st;
    logic       rdy;
    logic [1:0] cause;
  } step_t;

  step_t trace[$];
  int total = 0;
  int bad   = 0;

  localparam int K_LOAD = 0, K_STORE = 1, K_R = 2, K_I = 3, K_JAL = 4, K_JALR = 5,
                 K_LUI = 6, K_AUIPC = 7, K_BR = 8, K_ILL = 9;

  // Expected outputs straight from the per-state output table
  function automatic logic [17:0] exp_out(state_e st, logic r, logic [1:0] c);
    logic mreq = 0, pcu = 0, br = 0, rw = 0, mw = 0, irw = 0, adr = 0, tr = 0;
    logic [1:0] a = 0, b = 0, rs = 0, aop = 0, cs = 0;
    case (st)
      S_FETCH:    begin mreq = 1; b = 2'b10; rs = 2'b10; irw = r; pcu = r; end
      S_DECODE:   begin a = 2'b01; b = 2'b01; end
      S_MEMADR:   begin a = 2'b10; b = 2'b01; end
      S_MEMREAD:  begin mreq = 1; adr = 1; end
      S_MEMWB:    begin rw = 1; rs = 2'b01; end
      S_MEMWRITE: begin mreq = 1; adr = 1; mw = r; end
      S_EXECR:    begin a = 2'b10; b = 2'b00; aop = 2'b10; end
      S_EXECI:    begin a = 2'b10; b = 2'b01; aop = 2'b10; end
      S_JALR:     begin a = 2'b10; b = 2'b01; end
      S_JAL:      begin a = 2'b01; b = 2'b10; pcu = 1; end
      S_LUI:      begin a = 2'b11; b = 2'b01; end
      S_AUIPC:    begin a = 2'b01; b = 2'b01; end
      S_ALUWB:    begin rw = 1; end
      S_BRANCH:   begin a = 2'b10; aop = 2'b01; br = 1; end
      S_TRAP:     begin tr = 1; cs = c; end
      default: ;
    endcase
    return {mreq, pcu, br, rw, mw, irw, adr, a, b, rs, aop, tr, cs};
  endfunction

  function automatic logic [6:0] op_of(int k);
    case (k)
      K_LOAD:  return 7'b0000011;
      K_STORE: return 7'b0100011;
      K_R:     return 7'b0110011;
      K_I:     return 7'b0010011;
      K_JAL:   return 7'b1101111;
      K_JALR:  return 7'b1100111;
      K_LUI:   return 7'b0110111;
      K_AUIPC: return 7'b0010111;
      K_BR:    return 7'b1100011;
      default: return 7'b0000000;
    endcase
  endfunction

  function automatic bit is_legal(logic [6:0] o);
    for (int k = 0; k < K_ILL; k++)
      if (op_of(k) == o) return 1'b1;
    return 1'b0;
  endfunction

  task automatic check(string tag, logic [31:0] o, logic [31:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic push(state_e st, logic r, logic [1:0] c = 2'b00);
    step_t s;
    s.st = st; s.rdy = r; s.cause = c;
    trace.push_back(s);
  endtask

  task automatic push_mem(state_e st, int waits);
    for (int i = 0; i < waits; i++) push(st, 1'b0);
    push(st, 1'b1);
  endtask

  // One instruction as the sequence of states it must visit, with handshake waits inserted
  task automatic build(int k, int fw, int mw);
    trace.delete();
    push_mem(S_FETCH, fw);
    push(S_DECODE, 1'($urandom));
    case (k)
      K_LOAD:  begin push(S_MEMADR, 1'($urandom)); push_mem(S_MEMREAD, mw); push(S_MEMWB, 1'($urandom)); end
      K_STORE: begin push(S_MEMADR, 1'($urandom)); push_mem(S_MEMWRITE, mw); end
      K_R:     begin push(S_EXECR, 1'($urandom)); push(S_ALUWB, 1'($urandom)); end
      K_I:     begin push(S_EXECI, 1'($urandom)); push(S_ALUWB, 1'($urandom)); end
      K_JAL:   begin push(S_JAL, 1'($urandom)); push(S_ALUWB, 1'($urandom)); end
      K_JALR:  begin push(S_JALR, 1'($urandom)); push(S_JAL, 1'($urandom)); push(S_ALUWB, 1'($urandom)); end
      K_LUI:   begin push(S_LUI, 1'($urandom)); push(S_ALUWB, 1'($urandom)); end
      K_AUIPC: begin push(S_AUIPC, 1'($urandom)); push(S_ALUWB, 1'($urandom)); end
      K_BR:    push(S_BRANCH, 1'($urandom));
      default: ;
    endcase
  endtask

  task automatic run_trace(string tag, logic [6:0] op_v, int exp_irw);
    int irw = 0;
    for (int i = 0; i < trace.size(); i++) begin
      @(negedge clk);
      op        = op_v;
      mem_ready = trace[i].rdy;
      #1;
      check($sformatf("%s.c%0d.state", tag, i), 32'(state), 32'(trace[i].st));
      check($sformatf("%s.c%0d.outs", tag, i), 32'(obs),
            32'(exp_out(trace[i].st, trace[i].rdy, trace[i].cause)));
      irw += int'(IRWrite);
    end
    check({tag, ".irwrite_pulses"}, 32'(irw), 32'(exp_irw));
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("reset.outs", 32'(obs), 32'd0);
    check("reset.state", 32'(state), 32'(S_FETCH));
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("reset.release_outs_held", 32'(obs), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] ill;
    reset_n   = 1'b0;
    mem_ready = 1'b1;
    op        = 7'b0110011;
    do_reset();

    build(K_R, 0, 0);      run_trace("rtype", op_of(K_R), 1);
    build(K_LOAD, 0, 3);   run_trace("load_wait3", op_of(K_LOAD), 1);
    build(K_STORE, 1, 2);  run_trace("store_late", op_of(K_STORE), 1);
    build(K_JALR, 0, 0);   run_trace("jalr", op_of(K_JALR), 1);
    build(K_BR, 0, 0);     run_trace("branch", op_of(K_BR), 1);

    for (int n = 0; n < 40; n++) begin
      int k;
      k = $urandom_range(0, 8);
      build(k, $urandom_range(0, 3), $urandom_range(0, 3));
      run_trace($sformatf("rnd%0d_k%0d", n, k), op_of(k), 1);
    end

    ill = 7'b0000000;
    build(K_ILL, 0, 0);
`ifdef MCTRL_TRAP_EN
    push(S_TRAP, 1'b1, 2'b01); push(S_TRAP, 1'b0, 2'b01); push(S_TRAP, 1'b1, 2'b01);
    run_trace("illegal_trap", ill, 1);
    do_reset();

    trace.delete();
    for (int i = 0; i < 16; i++) push(S_FETCH, 1'b0);
    push(S_TRAP, 1'b0, 2'b10); push(S_TRAP, 1'b1, 2'b10);
    run_trace("fetch_timeout", op_of(K_R), 0);
    do_reset();
`else
    run_trace("illegal_nop", ill, 1);
`endif

    for (int n = 0; n < 3; n++) begin
      do begin
        ill = 7'($urandom);
      end while (is_legal(ill));
      build(K_ILL, $urandom_range(0, 2), 0);
`ifdef MCTRL_TRAP_EN
      push(S_TRAP, 1'b0, 2'b01);
      run_trace($sformatf("rnd_illegal%0d", n), ill, 1);
      do_reset();
`else
      run_trace($sformatf("rnd_illegal%0d", n), ill, 1);
`endif
    end

    build(K_STORE, 0, 0);  run_trace("store_after_illegal", op_of(K_STORE), 1);

    // Reset dropped mid-wait must clear every output without a clock edge
    trace.delete();
    push(S_FETCH, 1'b0); push(S_FETCH, 1'b0); push(S_FETCH, 1'b0);
    run_trace("midwait", op_of(K_LOAD), 0);
    @(negedge clk);
    mem_ready = 1'b1;
    #2;
    reset_n = 1'b0;
    #1;
    check("midwait.async_outs", 32'(obs), 32'd0);
    @(negedge clk);
    check("midwait.held_outs", 32'(obs), 32'd0);
    reset_n = 1'b1;
    #1;
    check("midwait.release_outs_held", 32'(obs), 32'd0);

    build(K_LUI, 0, 0);    run_trace("lui_after_reset", op_of(K_LUI), 1);
    build(K_AUIPC, 2, 0);  run_trace("auipc", op_of(K_AUIPC), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
